// File: rtl/alu_seq_ctrl_pkg.sv
// Shared opcodes, ALU control codes and FSM states for the ALU sequencer.
// Optional multiply support is enabled by defining ALU_SEQ_MUL_EN.
package alu_seq_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;

  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_SUB = 4'b0110;
  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_SLT = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_RESP
  } state_t;

  function automatic logic [3:0] op_to_aluc(input logic [2:0] op);
    logic [3:0] c;
    case (op)
      OP_SUB:  c = ALUC_SUB;
      OP_AND:  c = ALUC_AND;
      OP_OR:   c = ALUC_OR;
      OP_SLT:  c = ALUC_SLT;
      default: c = ALUC_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; last_grant holds the index of the most recent winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= 1'b1;
    else if (advance && (|gnt))
      last_grant <= gnt[1];
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Define ALU_SEQ_MUL_EN to build the shift-add multiply (op 5); otherwise op 5 is illegal.
module alu_seq_ctrl #(
  parameter int W         = 32,
  parameter int MUL_ITERS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [W-1:0] resp_result,
  output logic         resp_zf,
  output logic         resp_err,
  output logic [W-1:0] alu_op1,
  output logic [W-1:0] alu_op2,
  output logic [3:0]   alu_ctrl,
  input  logic [W-1:0] alu_result,
  input  logic         alu_zf
);
  import alu_seq_ctrl_pkg::*;

  if (MUL_ITERS != W) begin : g_bad_iters
    $error("MUL_ITERS must equal W");
  end

  state_t       state, state_nxt;
  logic [2:0]   op_q;
  logic [W-1:0] a_q, b_q;
  logic [1:0]   gnt;
  logic         idle, accept, sel_id, sel_legal;
  logic [2:0]   sel_op;
  logic [W-1:0] sel_a, sel_b;

  assign idle       = (state == S_IDLE);
  assign accept     = idle && (|gnt);
  assign req0_ready = idle && gnt[0];
  assign req1_ready = idle && gnt[1];
  assign resp_valid = (state == S_RESP);

  assign sel_id = gnt[1];
  assign sel_op = sel_id ? req1_op : req0_op;
  assign sel_a  = sel_id ? req1_a  : req0_a;
  assign sel_b  = sel_id ? req1_b  : req0_b;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1_valid, req0_valid}),
    .advance (accept),
    .gnt     (gnt)
  );

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(MUL_ITERS);
  logic [CW-1:0] cnt;
  logic [W-1:0]  acc, mcand, mplier;
  logic          mul_last;

  assign mul_last  = (cnt == CW'(MUL_ITERS - 1));
  assign sel_legal = (sel_op <= OP_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (accept) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= sel_a;
      mplier <= sel_b;
    end else if (state == S_MUL) begin
      cnt    <= cnt + CW'(1);
      acc    <= alu_result;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`else
  assign sel_legal = (sel_op <= OP_SLT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!sel_legal)
            state_nxt = S_RESP;
`ifdef ALU_SEQ_MUL_EN
          else if (sel_op == OP_MUL)
            state_nxt = S_MUL;
`endif
          else
            state_nxt = S_EXEC;
        end
      end
      S_EXEC: state_nxt = S_RESP;
`ifdef ALU_SEQ_MUL_EN
      S_MUL:  if (mul_last) state_nxt = S_RESP;
`endif
      S_RESP: if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    alu_op1  = '0;
    alu_op2  = '0;
    alu_ctrl = ALUC_ADD;
    case (state)
      S_EXEC: begin
        alu_op1  = a_q;
        alu_op2  = b_q;
        alu_ctrl = op_to_aluc(op_q);
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        alu_op1 = acc;
        alu_op2 = mplier[0] ? mcand : '0;
      end
`endif
      default: ;
    endcase
  end

  // Illegal ops preload result 0 / zf 1; legal ops overwrite them before RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zf     <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q        <= sel_op;
            a_q         <= sel_a;
            b_q         <= sel_b;
            resp_id     <= sel_id;
            resp_err    <= !sel_legal;
            resp_result <= '0;
            resp_zf     <= 1'b1;
          end
        end
        S_EXEC: begin
          resp_result <= alu_result;
          resp_zf     <= alu_zf;
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: begin
          if (mul_last) begin
            resp_result <= alu_result;
            resp_zf     <= (alu_result == '0);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural ALU and reference model.
// Honours ALU_SEQ_MUL_EN the same way as the design.
module tb_alu_seq_ctrl;

  localparam int W         = 32;
  localparam int MUL_ITERS = 32;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         resp_valid, resp_ready = 1'b0;
  logic         resp_id, resp_zf, resp_err;
  logic [W-1:0] resp_result;
  logic [W-1:0] alu_op1, alu_op2, alu_result;
  logic [3:0]   alu_ctrl;
  logic         alu_zf;

  int n_vec = 0;
  int n_err = 0;
  logic mdl_last = 1'b1;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.W(W), .MUL_ITERS(MUL_ITERS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zf(resp_zf), .resp_err(resp_err),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zf(alu_zf)
  );

  // Behavioural ALU as the sequencer sees it.
  always_comb begin
    case (alu_ctrl)
      4'b0010: alu_result = alu_op1 + alu_op2;
      4'b0110: alu_result = alu_op1 - alu_op2;
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 | alu_op2;
      4'b0111: alu_result = (alu_op1 < alu_op2) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
    alu_zf = (alu_result == '0);
  end

  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic zf, output logic err,
                                 output int lat, output logic [3:0] ctrl);
    err = 1'b0; lat = 2; r = '0; ctrl = 4'b0010;
    case (op)
      3'd0: r = a + b;
      3'd1: begin r = a - b; ctrl = 4'b0110; end
      3'd2: begin r = a & b; ctrl = 4'b0000; end
      3'd3: begin r = a | b; ctrl = 4'b0001; end
      3'd4: begin r = (a < b) ? 32'd1 : 32'd0; ctrl = 4'b0111; end
      3'd5: if (MUL_EN) begin r = a * b; lat = MUL_ITERS + 1; end
            else begin err = 1'b1; lat = 1; end
      default: begin err = 1'b1; lat = 1; end
    endcase
    zf = (r == '0);
  endfunction

  function automatic logic pick(input logic [1:0] mask);
    logic w;
    w = (mask == 2'b11) ? ~mdl_last : mask[1];
    mdl_last = w;
    return w;
  endfunction

  // Presents a request pattern and completes one transaction; reports what was observed.
  task automatic run_op(input logic [1:0] mask,
                        input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                        output logic wid, output logic [31:0] r, output logic zf, output logic err,
                        output int lat, output logic [3:0] ectrl, output logic to);
    int k;
    to = 1'b0; wid = 1'b0; r = '0; zf = 1'b0; err = 1'b0; lat = 0; ectrl = '0;
    @(negedge clk);
    req0_valid = mask[0]; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = mask[1]; req1_op = op1; req1_a = a1; req1_b = b1;
    #1;
    k = 0;
    while (!(req0_ready || req1_ready) && k < 20) begin
      @(negedge clk); #1; k++;
    end
    if (!(req0_ready || req1_ready)) begin
      to = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    wid = req1_ready;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (lat == 1) begin
        ectrl = alu_ctrl; req0_valid = 1'b0; req1_valid = 1'b0;
      end
    end while (!resp_valid && lat < 100);
    if (!resp_valid) begin
      to = 1'b1;
      return;
    end
    r = resp_result; zf = resp_zf; err = resp_err;
    wid = resp_id;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
    n_vec++; if ({resp_id, resp_zf, resp_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {resp_id, resp_zf, resp_err}); end
    n_vec++; if (resp_result !== '0) begin n_err++; $display("FAIL reset_result got=%h exp=0", resp_result); end
    n_vec++; if ({alu_ctrl, alu_op1, alu_op2} !== {4'b0010, 64'd0}) begin n_err++; $display("FAIL reset_alu got ctrl=%b op1=%h op2=%h exp 0010/0/0", alu_ctrl, alu_op1, alu_op2); end
  endtask

  task automatic test_add;
    logic wid, zf, err, to; logic [31:0] r; int lat; logic [3:0] ec;
    run_op(2'b01, 3'd0, 32'd5, 32'd7, 3'd0, 32'd0, 32'd0, wid, r, zf, err, lat, ec, to);
    void'(pick(2'b01));
    n_vec++; if (to) begin n_err++; $display("FAIL add_timeout got=timeout exp=response"); end
    n_vec++; if ({wid, zf, err} !== 3'b000 || r !== 32'd12) begin n_err++; $display("FAIL add_resp got id=%b r=%0d zf=%b err=%b exp 0/12/0/0", wid, r, zf, err); end
    n_vec++; if (lat != 2) begin n_err++; $display("FAIL add_latency got=%0d exp=2", lat); end
    n_vec++; if (ec !== 4'b0010) begin n_err++; $display("FAIL add_ctrl got=%b exp=0010", ec); end
  endtask

  task automatic test_tie;
    logic wid, zf, err, to, ew; logic [31:0] r; int lat; logic [3:0] ec;
    for (int i = 0; i < 3; i++) begin
      run_op(2'b11, 3'd1, 32'd9, 32'd9, 3'd3, 32'hF0, 32'h0F, wid, r, zf, err, lat, ec, to);
      ew = pick(2'b11);
      n_vec++; if (to || wid !== ew) begin n_err++; $display("FAIL tie_grant[%0d] got=%b to=%b exp=%b", i, wid, to, ew); end
      n_vec++; if (r !== (ew ? 32'hFF : 32'h0) || zf !== ~ew || err !== 1'b0) begin
        n_err++; $display("FAIL tie_result[%0d] got r=%h zf=%b err=%b exp r=%h zf=%b", i, r, zf, err, ew ? 32'hFF : 32'h0, ~ew);
      end
    end
  endtask

  task automatic test_hold;
    int k;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 32'd3; req0_b = 32'hFFFF_FFFF;
    #1;
    k = 0;
    while (!req0_ready && k < 20) begin @(negedge clk); #1; k++; end
    n_vec++; if (!req0_ready) begin n_err++; $display("FAIL hold_accept got=0 exp=1"); end
    void'(pick(2'b01));
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b1;
    k = 0;
    while (!resp_valid && k < 20) begin @(negedge clk); k++; end
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (resp_valid !== 1'b1 || resp_result !== 32'd1 || resp_id !== 1'b0) begin
        n_err++; $display("FAIL hold_stable[%0d] got v=%b r=%h id=%b exp 1/1/0", i, resp_valid, resp_result, resp_id);
      end
      n_vec++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL hold_ready[%0d] got=%b exp=00", i, {req0_ready, req1_ready}); end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_directed_ops;
    logic [2:0]  ops [4] = '{3'd5, 3'd5, 3'd7, 3'd6};
    logic [31:0] as  [4] = '{32'h10000, 32'd6, 32'd1, 32'd2};
    logic [31:0] bs  [4] = '{32'h10000, 32'd7, 32'd1, 32'd3};
    logic wid, zf, err, to, ezf, eerr; logic [31:0] r, er; int lat, elat; logic [3:0] ec, ectl;
    for (int i = 0; i < 4; i++) begin
      run_op(2'b01, ops[i], as[i], bs[i], 3'd0, 32'd0, 32'd0, wid, r, zf, err, lat, ec, to);
      void'(pick(2'b01));
      ref_op(ops[i], as[i], bs[i], er, ezf, eerr, elat, ectl);
      n_vec++; if (to || r !== er || zf !== ezf || err !== eerr) begin
        n_err++; $display("FAIL op%0d_resp[%0d] got r=%h zf=%b err=%b to=%b exp r=%h zf=%b err=%b", ops[i], i, r, zf, err, to, er, ezf, eerr);
      end
      n_vec++; if (lat != elat) begin n_err++; $display("FAIL op%0d_latency[%0d] got=%0d exp=%0d", ops[i], i, lat, elat); end
    end
  endtask

  task automatic test_random;
    logic [1:0] mask; logic [2:0] o0, o1, eop; logic [31:0] a0, b0, a1, b1, ea, eb;
    logic wid, zf, err, to, ew, ezf, eerr; logic [31:0] r, er; int lat, elat; logic [3:0] ec, ectl;
    for (int i = 0; i < 40; i++) begin
      mask = 2'($urandom_range(1, 3));
      o0 = 3'($urandom_range(0, 7)); o1 = 3'($urandom_range(0, 7));
      a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      a1 = $urandom_range(0, 15); b1 = $urandom;
      run_op(mask, o0, a0, b0, o1, a1, b1, wid, r, zf, err, lat, ec, to);
      ew = pick(mask);
      eop = ew ? o1 : o0; ea = ew ? a1 : a0; eb = ew ? b1 : b0;
      ref_op(eop, ea, eb, er, ezf, eerr, elat, ectl);
      n_vec++; if (to || wid !== ew || r !== er || zf !== ezf || err !== eerr || lat != elat) begin
        n_err++;
        $display("FAIL rand[%0d] op=%0d got id=%b r=%h zf=%b err=%b lat=%0d to=%b exp id=%b r=%h zf=%b err=%b lat=%0d",
                 i, eop, wid, r, zf, err, lat, to, ew, er, ezf, eerr, elat);
      end
      if (elat == 2) begin
        n_vec++; if (ec !== ectl) begin n_err++; $display("FAIL rand_ctrl[%0d] got=%b exp=%b", i, ec, ectl); end
      end
    end
  endtask

  task automatic test_reset_abort;
    int k;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = MUL_EN ? 3'd5 : 3'd0; req0_a = 32'd123; req0_b = 32'd456;
    #1;
    k = 0;
    while (!req0_ready && k < 20) begin @(negedge clk); #1; k++; end
    @(posedge clk);
    req0_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    mdl_last = 1'b1;
    #1;
    n_vec++; if (resp_valid !== 1'b0 || resp_result !== '0 || resp_err !== 1'b0) begin
      n_err++; $display("FAIL abort_resp got v=%b r=%h err=%b exp 0/0/0", resp_valid, resp_result, resp_err);
    end
    n_vec++; if (alu_ctrl !== 4'b0010 || alu_op1 !== '0 || alu_op2 !== '0) begin
      n_err++; $display("FAIL abort_alu got ctrl=%b op1=%h op2=%h exp 0010/0/0", alu_ctrl, alu_op1, alu_op2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL abort_noresp[%0d] got=%b exp=0", i, resp_valid); end
    end
    req0_valid = 1'b1; req0_op = 3'd0;
    #1;
    n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got=%b exp=1", req0_ready); end
    req0_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    #23;
    test_reset;
    rst_n = 1'b1;
    test_add;
    test_tie;
    test_hold;
    test_directed_ops;
    test_random;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
